// File: rtl/spec_pkg.sv
// Shared sizing helpers for the spectrum averager and its accumulator RAM.
package spec_pkg;

  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned avg_log2);
    return 2 * data_width + avg_log2;
  endfunction

  // {ch,k} accumulator address: one channel bit above the bin index
  function automatic int unsigned addr_width(input int unsigned n_fft);
    return $clog2(n_fft) + 1;
  endfunction

endpackage

// File: rtl/Axis_If.sv
// Minimal AXI-Stream bundle: valid/ready handshake, data payload and frame-end marker.
interface Axis_If #(
  parameter int unsigned DWIDTH = 48
);
  logic              valid;
  logic              ready;
  logic [DWIDTH-1:0] data;
  logic              last;

  modport Master (output valid, output data, output last, input ready);
  modport Slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/avg_acc_ram.sv
// Simple dual-port accumulator RAM, one write port and a registered read port with enable.
// Behaviourally matches an SDP block RAM with READ_LATENCY_B = 1.
module avg_acc_ram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 50
) (
  input  logic          clk,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  // Read output holds while i_rd_en is low so a stalled pipeline keeps its operand
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/spectrum_averager.sv
// Per-bin power (re^2 + im^2) averaged over 2^AVG_LOG2 L/R frame pairs; the final frame of
// each period is streamed out per channel. Four-stage pipeline, frozen as a whole on backpressure.
module spectrum_averager
  import spec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned N_FFT      = 512,
  parameter int unsigned AVG_LOG2   = 2
) (
  input  logic   clk,
  input  logic   reset_n,
  Axis_If.Slave  data_in,
  Axis_If.Master data_out,
  output logic   out_channel,
  output logic   frame_err
);
  localparam int unsigned PW    = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W = acc_width(DATA_WIDTH, AVG_LOG2);
  localparam int unsigned KW    = $clog2(N_FFT);
  localparam int unsigned AW    = addr_width(N_FFT);
  localparam int unsigned FW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_FFT - 1);
  localparam logic [FW-1:0] F_LAST = FW'((1 << AVG_LOG2) - 1);

  logic                         w_advance;
  logic                         w_hs;
  logic signed [DATA_WIDTH-1:0] w_in_re;
  logic signed [DATA_WIDTH-1:0] w_in_im;

  logic [KW-1:0] r_k;
  logic          r_ch;
  logic [FW-1:0] r_f;
  logic          r_rdy_en;
  logic          r_frame_err;

  logic                         r_s0_valid;
  logic signed [DATA_WIDTH-1:0] r_s0_re;
  logic signed [DATA_WIDTH-1:0] r_s0_im;
  logic                         r_s0_ch;
  logic [KW-1:0]                r_s0_k;
  logic                         r_s0_first;
  logic                         r_s0_emit;

  logic [PW-1:0] w_re_sq;
  logic [PW-1:0] w_im_sq;
  logic          r_s1_valid;
  logic [PW-1:0] r_s1_re_sq;
  logic [PW-1:0] r_s1_im_sq;
  logic          r_s1_ch;
  logic [KW-1:0] r_s1_k;
  logic          r_s1_first;
  logic          r_s1_emit;

  logic [ACC_W-1:0] w_rd_data;
  logic [ACC_W-1:0] w_acc;
  logic [ACC_W-1:0] w_sum;
  logic             r_s2_valid;
  logic [ACC_W-1:0] r_s2_sum;
  logic             r_s2_ch;
  logic [KW-1:0]    r_s2_k;
  logic             r_s2_emit;

  logic w_wr_en;

  // Whole pipeline freezes only while an emitted beat waits for the consumer
  assign w_advance     = !(data_out.valid && !data_out.ready);
  assign data_in.ready = r_rdy_en && w_advance;
  assign w_hs          = data_in.valid && r_rdy_en && w_advance;
  assign w_in_re       = data_in.data[DATA_WIDTH-1:0];
  assign w_in_im       = data_in.data[PW-1:DATA_WIDTH];
  assign frame_err     = r_frame_err;

  // Input position: bin k, channel ch, pair counter f
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k         <= '0;
      r_ch        <= 1'b0;
      r_f         <= '0;
      r_rdy_en    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_hs) begin
        if (data_in.last != (r_k == K_LAST)) begin
          r_frame_err <= 1'b1;
        end
        if (data_in.last) begin
          r_k  <= '0;
          r_ch <= !r_ch;
          if (r_ch) begin
            r_f <= (r_f == F_LAST) ? '0 : r_f + FW'(1);
          end
        end else begin
          r_k <= r_k + KW'(1);
        end
      end
    end
  end

  // S0: operands and per-beat control captured at the handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s0_valid <= 1'b0;
      r_s0_re    <= '0;
      r_s0_im    <= '0;
      r_s0_ch    <= 1'b0;
      r_s0_k     <= '0;
      r_s0_first <= 1'b0;
      r_s0_emit  <= 1'b0;
    end else if (w_advance) begin
      r_s0_valid <= w_hs;
      if (w_hs) begin
        r_s0_re    <= w_in_re;
        r_s0_im    <= w_in_im;
        r_s0_ch    <= r_ch;
        r_s0_k     <= r_k;
        r_s0_first <= (r_f == '0);
        r_s0_emit  <= (r_f == F_LAST);
      end
    end
  end

  assign w_re_sq = PW'(r_s0_re) * PW'(r_s0_re);
  assign w_im_sq = PW'(r_s0_im) * PW'(r_s0_im);

  // S1: squares registered alongside the accumulator read returning from the RAM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_re_sq <= '0;
      r_s1_im_sq <= '0;
      r_s1_ch    <= 1'b0;
      r_s1_k     <= '0;
      r_s1_first <= 1'b0;
      r_s1_emit  <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= r_s0_valid;
      r_s1_re_sq <= w_re_sq;
      r_s1_im_sq <= w_im_sq;
      r_s1_ch    <= r_s0_ch;
      r_s1_k     <= r_s0_k;
      r_s1_first <= r_s0_first;
      r_s1_emit  <= r_s0_emit;
    end
  end

  // First frame of a period ignores whatever the RAM holds
  assign w_acc = r_s1_first ? '0 : w_rd_data;
  assign w_sum = ACC_W'(r_s1_re_sq) + ACC_W'(r_s1_im_sq) + w_acc;

  // S2: running sum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_ch    <= 1'b0;
      r_s2_k     <= '0;
      r_s2_emit  <= 1'b0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sum   <= w_sum;
      r_s2_ch    <= r_s1_ch;
      r_s2_k     <= r_s1_k;
      r_s2_emit  <= r_s1_emit;
    end
  end

  assign w_wr_en = w_advance && r_s2_valid && !r_s2_emit;

  // S3: output register; payload only reloads on an emitted beat so it holds across stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out.valid <= 1'b0;
      data_out.last  <= 1'b0;
      data_out.data  <= '0;
      out_channel    <= 1'b0;
    end else if (w_advance) begin
      data_out.valid <= r_s2_valid && r_s2_emit;
      data_out.last  <= r_s2_valid && r_s2_emit && (r_s2_k == K_LAST);
      if (r_s2_valid && r_s2_emit) begin
        data_out.data <= PW'(r_s2_sum >> AVG_LOG2);
        out_channel   <= r_s2_ch;
      end
    end
  end

  avg_acc_ram #(
    .AW (AW),
    .DW (ACC_W)
  ) u_ram (
    .clk       (clk),
    .i_rd_en   (w_advance),
    .i_rd_addr ({r_s0_ch, r_s0_k}),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_wr_en),
    .i_wr_addr ({r_s2_ch, r_s2_k}),
    .i_wr_data (r_s2_sum)
  );

endmodule

// File: tb/tb_spectrum_averager.sv
// Directed bench for spectrum_averager: one instance without averaging, one averaging 4 pairs.
module tb_spectrum_averager;
  localparam int unsigned DW = 24;
  localparam int unsigned PW = 48;
  localparam int          NF = 16;

  typedef struct {
    logic [PW-1:0] d;
    logic          l;
    logic          c;
    int            cyc;
  } beat_t;

  logic clk;
  logic reset_n;
  logic out_ch0, out_ch2;
  logic ferr0, ferr2;

  Axis_If #(.DWIDTH(PW)) in0 ();
  Axis_If #(.DWIDTH(PW)) out0 ();
  Axis_If #(.DWIDTH(PW)) in2 ();
  Axis_If #(.DWIDTH(PW)) out2 ();

  spectrum_averager #(.DATA_WIDTH(DW), .N_FFT(NF), .AVG_LOG2(0)) u_dut0 (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_in     (in0),
    .data_out    (out0),
    .out_channel (out_ch0),
    .frame_err   (ferr0)
  );

  spectrum_averager #(.DATA_WIDTH(DW), .N_FFT(NF), .AVG_LOG2(2)) u_dut2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_in     (in2),
    .data_out    (out2),
    .out_channel (out_ch2),
    .frame_err   (ferr2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 0;
  bit bp_en   = 0;

  int            fr_re [NF];
  int            fr_im [NF];
  logic [PW-1:0] exp_d [NF];
  beat_t         q0 [$];
  beat_t         q2 [$];

  logic          prev_stall = 0;
  logic [PW-1:0] prev_d;
  logic          prev_l, prev_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  // Consumer side of the averaging instance: random backpressure when enabled
  initial begin
    out2.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out2.ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset_n && out0.valid && out0.ready)
      q0.push_back('{d: out0.data, l: out0.last, c: out_ch0, cyc: cyc});
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_tests++;
        assert (out2.valid === 1'b1 && out2.data === prev_d && out2.last === prev_l && out_ch2 === prev_c)
        else begin
          n_fail++;
          $error("FAIL stall_hold: observed v=%b d=%0d l=%b c=%b expected v=1 d=%0d l=%b c=%b",
                 out2.valid, out2.data, out2.last, out_ch2, prev_d, prev_l, prev_c);
        end
      end
      if (mon_en) begin
        n_tests++;
        assert (in2.ready === !(out2.valid && !out2.ready))
        else begin
          n_fail++;
          $error("FAIL ready_mirror: observed %b expected %b", in2.ready, !(out2.valid && !out2.ready));
        end
      end
      if (out2.valid && out2.ready)
        q2.push_back('{d: out2.data, l: out2.last, c: out_ch2, cyc: cyc});
      prev_stall = out2.valid && !out2.ready;
      prev_d     = out2.data;
      prev_l     = out2.last;
      prev_c     = out_ch2;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < NF; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
      exp_d[i] = '0;
    end
  endtask

  task automatic drive_beat(input bit sel, input logic [PW-1:0] d, input logic l, output int hs_cyc);
    logic hs;
    int   waits;
    hs    = 1'b0;
    waits = 0;
    if (sel) begin
      in2.valid = 1'b1; in2.data = d; in2.last = l;
    end else begin
      in0.valid = 1'b1; in0.data = d; in0.last = l;
    end
    while (!hs && waits < 200) begin
      @(negedge clk);
      hs = sel ? in2.ready : in0.ready;
      @(posedge clk);
      #1;
      waits++;
    end
    hs_cyc = cyc;
    check("beat_accept", 64'(hs), 64'd1);
  endtask

  task automatic send_frame(input bit sel, input int nb, input int last_idx, output int first_cyc);
    int hc;
    first_cyc = 0;
    for (int i = 0; i < nb; i++) begin
      drive_beat(sel, {DW'(fr_im[i]), DW'(fr_re[i])}, (i == last_idx), hc);
      if (i == 0) first_cyc = hc;
    end
    if (sel) begin
      in2.valid = 1'b0; in2.last = 1'b0;
    end else begin
      in0.valid = 1'b0; in0.last = 1'b0;
    end
  endtask

  task automatic wait_out(input bit sel, input int n, input string tag);
    int c;
    c = 0;
    while ((sel ? q2.size() : q0.size()) < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    repeat (6) @(negedge clk);
    check({tag, "_count"}, 64'(sel ? q2.size() : q0.size()), 64'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input bit sel, input string tag, input int nb, input logic exp_c,
                             input int last_idx);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      if ((sel ? q2.size() : q0.size()) == 0) return;
      if (sel) b = q2.pop_front();
      else     b = q0.pop_front();
      check($sformatf("%s_data%0d", tag, i), 64'(b.d), 64'(exp_d[i]));
      check($sformatf("%s_last%0d", tag, i), 64'(b.l), 64'(i == last_idx));
      check($sformatf("%s_chan%0d", tag, i), 64'(b.c), 64'(exp_c));
    end
  endtask

  initial begin
    int c;
    int h0;
    reset_n    = 1'b0;
    in0.valid  = 1'b0; in0.data = '0; in0.last = 1'b0;
    in2.valid  = 1'b0; in2.data = '0; in2.last = 1'b0;
    out0.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out2.valid), 64'd0);
    check("rst_last",  64'(out2.last), 64'd0);
    check("rst_data",  64'(out2.data), 64'd0);
    check("rst_chan",  64'(out_ch2), 64'd0);
    check("rst_ferr",  64'(ferr2), 64'd0);
    check("rst_ready", 64'(in2.ready), 64'd0);
    reset_n = 1'b1;
    #1;
    check("ready_pre_edge", 64'(in2.ready), 64'd0);
    @(posedge clk);
    #1;
    check("ready_post_edge", 64'(in2.ready), 64'd1);
    mon_en = 1'b1;

    // Averaging: only the 4th pair is emitted, bin0 = 4*1e6 >> 2
    for (int p = 0; p < 4; p++) begin
      clear_frame(); fr_re[0] = 1000;
      send_frame(1, NF, NF - 1, c);
      clear_frame();
      send_frame(1, NF, NF - 1, c);
      if (p == 2) wait_out(1, 0, "avg_quiet");
    end
    wait_out(1, 2 * NF, "avg_emit");
    clear_frame(); exp_d[0] = 48'd1000000;
    check_frame(1, "avg_l", NF, 1'b0, NF - 1);
    clear_frame();
    check_frame(1, "avg_r", NF, 1'b1, NF - 1);

    // Full scale: (-2^23,-2^23) everywhere -> 2^47 per bin
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < NF; i++) begin
        fr_re[i] = -8388608;
        fr_im[i] = -8388608;
      end
      send_frame(1, NF, NF - 1, c);
    end
    wait_out(1, 2 * NF, "fs");
    for (int i = 0; i < NF; i++) exp_d[i] = 48'h8000_0000_0000;
    check_frame(1, "fs_l", NF, 1'b0, NF - 1);
    check_frame(1, "fs_r", NF, 1'b1, NF - 1);

    // Backpressure with distinct per-bin powers: left (k+1)^2, right (k+2)^2
    bp_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      clear_frame();
      for (int i = 0; i < NF; i++) fr_re[i] = i + 1;
      send_frame(1, NF, NF - 1, c);
      clear_frame();
      for (int i = 0; i < NF; i++) fr_im[i] = i + 2;
      send_frame(1, NF, NF - 1, c);
    end
    wait_out(1, 2 * NF, "bp");
    bp_en = 1'b0;
    for (int i = 0; i < NF; i++) exp_d[i] = PW'((i + 1) * (i + 1));
    check_frame(1, "bp_l", NF, 1'b0, NF - 1);
    for (int i = 0; i < NF; i++) exp_d[i] = PW'((i + 2) * (i + 2));
    check_frame(1, "bp_r", NF, 1'b1, NF - 1);

    // No averaging: bin3 = (3,-4) -> 25, plus three-cycle latency
    clear_frame(); fr_re[3] = 3; fr_im[3] = -4;
    send_frame(0, NF, NF - 1, h0);
    clear_frame();
    send_frame(0, NF, NF - 1, c);
    wait_out(0, 2 * NF, "a0");
    if (q0.size() > 0) check("latency", 64'(q0[0].cyc - h0), 64'd3);
    exp_d[3] = 48'd25;
    check_frame(0, "a0_l", NF, 1'b0, NF - 1);
    clear_frame();
    check_frame(0, "a0_r", NF, 1'b1, NF - 1);
    check("ferr_clean", 64'(ferr0), 64'd0);

    // Short frame: last at k=9 flags the error, next frame is the right channel from k=0
    clear_frame(); fr_re[3] = 3; fr_im[3] = -4;
    send_frame(0, 10, 9, c);
    wait_out(0, 10, "short");
    exp_d[3] = 48'd25;
    check_frame(0, "short", 10, 1'b0, -1);
    check("ferr_set", 64'(ferr0), 64'd1);
    clear_frame(); fr_re[0] = 5; fr_im[0] = 12;
    send_frame(0, NF, NF - 1, c);
    wait_out(0, NF, "after_short");
    exp_d[0] = 48'd169;
    check_frame(0, "after_short", NF, 1'b1, NF - 1);
    check("ferr_sticky", 64'(ferr0), 64'd1);

    // Reset during accumulation (f=2) with a partial frame in flight
    for (int p = 0; p < 2; p++) begin
      clear_frame(); fr_re[0] = 1000;
      send_frame(1, NF, NF - 1, c);
      clear_frame();
      send_frame(1, NF, NF - 1, c);
    end
    clear_frame(); fr_re[0] = 1000;
    send_frame(1, 5, -1, c);
    for (int i = 0; i < NF; i++) begin
      fr_re[i] = 3;
      fr_im[i] = 4;
    end
    send_frame(0, 8, -1, c);
    check("pre_rst_valid", 64'(out0.valid), 64'd1);
    check("pre_rst_data", 64'(out0.data), 64'd25);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid0", 64'(out0.valid), 64'd0);
    check("mid_rst_data0", 64'(out0.data), 64'd0);
    check("mid_rst_ferr0", 64'(ferr0), 64'd0);
    check("mid_rst_valid2", 64'(out2.valid), 64'd0);
    check("mid_rst_ready2", 64'(in2.ready), 64'd0);
    q0.delete();
    check("mid_rst_q2", 64'(q2.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      clear_frame(); fr_im[0] = 7;
      send_frame(1, NF, NF - 1, c);
      clear_frame();
      send_frame(1, NF, NF - 1, c);
      if (p == 1) wait_out(1, 0, "post_rst_quiet");
    end
    wait_out(1, 2 * NF, "post_rst");
    clear_frame(); exp_d[0] = 48'd49;
    check_frame(1, "post_rst_l", NF, 1'b0, NF - 1);
    clear_frame();
    check_frame(1, "post_rst_r", NF, 1'b1, NF - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spectrum_averager.md
# spectrum_averager

Consumes the complex bin stream produced by the per-resolution FFT cores: left-channel frame, then right-channel frame, alternating. It computes the power of each bin as re² + im² and averages it over 2^AVG_LOG2 frames per channel in an accumulator RAM. On the final frame of each averaging period it emits the averaged power spectrum for that channel as an AXI-Stream frame. One instance sits behind each FFT, turning raw FFT output into display-ready spectra.

## Interface
Parameters:
- DATA_WIDTH, 24, width of each real/imag component (signed)
- N_FFT, 512, bins per frame (power of two, ≥ 16)
- AVG_LOG2, 2, log2 of frames averaged per channel (0 = no averaging)

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- data_in  Axis_If.Slave  DWIDTH=2*DATA_WIDTH  bins; [DATA_WIDTH-1:0] = re, [2*DATA_WIDTH-1:DATA_WIDTH] = im; last marks the frame's final bin
- data_out  Axis_If.Master  DWIDTH=2*DATA_WIDTH  averaged unsigned power per bin; last on bin N_FFT-1
- out_channel  out  1  channel of the frame currently on data_out (0 = left, 1 = right); stable for the whole frame
- frame_err  out  1  sticky; set on a frame-length mismatch

## Operation
- Input state:
  - bin counter k (log2 N_FFT bits)
  - channel bit ch
  - frame counter f (AVG_LOG2 bits, counts L/R frame pairs)
- Each data_in handshake issues RAM read address {ch,k}. Then k increments.
- On data_in.last:
  - k goes to 0 and ch toggles.
  - If ch was 1, f increments and wraps at 2^AVG_LOG2.
- Power: p = re² + im², computed unsigned in 2*DATA_WIDTH bits. It cannot overflow: max is 2^(2*DATA_WIDTH-1).
- Accumulator width is ACC_W = 2*DATA_WIDTH + AVG_LOG2. The RAM holds 2*N_FFT words of ACC_W bits.
- sum = p if f == 0 (stale RAM contents ignored), else p + acc[{ch,k}].
- If f < 2^AVG_LOG2-1, sum is written back to {ch,k} and nothing is emitted.
- If f == 2^AVG_LOG2-1:
  - sum >> AVG_LOG2 is emitted on data_out with out_channel = ch.
  - last is emitted iff k == N_FFT-1.
  - The RAM write-back is suppressed.
- Frame errors:
  - Triggers: last arrives with k ≠ N_FFT-1, or k == N_FFT-1 arrives without last.
  - frame_err is set in either case.
  - Frame boundaries always follow data_in.last. k wraps naturally.
  - frame_err clears only on reset.
- Read-modify-write hazards cannot occur: consecutive accesses to the same address are at least N_FFT ≥ 16 beats apart, and pipeline depth is 3.

## Timing
- Pipeline stages:
  - S0: handshake, RAM read issue, operand register
  - S1: squares registered, RAM data returns (1-cycle read)
  - S2: sum registered
  - S3: data_out register / RAM write
- Latency: bin accepted at cycle t appears on data_out at t+3 with no stall.
- Stall: advance = !(data_out.valid && !data_out.ready).
  - All stages, including the RAM read enable, hold while advance is low.
  - data_in.ready = advance.
  - Non-output frames never stall.
- data_out.valid, data, last and out_channel hold stable until the handshake.
- Reset values (asynchronous):
  - data_out.valid=0, data_out.last=0, data_out.data=0
  - out_channel=0, frame_err=0
  - k=0, ch=0, f=0, all stage valids 0
  - data_in.ready=1 from the first clk edge after reset_n rises
- Reset mid-frame: partial frames and partial averages are discarded. The next frame is treated as left, f=0. RAM is not cleared; f==0 masks its contents.
- Simultaneous last and stall: last is recorded only at the handshake.

## Structure
- Package spec_pkg holds:
  - function acc_width(DATA_WIDTH, AVG_LOG2)
  - localparam-style helper for the {ch,k} address width, clog2(N_FFT)+1
- Sub-module avg_acc_ram: simple dual-port RAM with registered read, read enable (for stall), write port. Implemented with xpm_memory_sdpram, READ_LATENCY_B=1.
- The rest (counters, pipeline, stall) stays in spectrum_averager.

## Test plan
- AVG_LOG2=0, N_FFT=16, bin 3 of the left frame = (re=3, im=-4), rest 0 → left output frame has 25 at index 3, 0 elsewhere, out_channel=0, last on index 15 only.
- AVG_LOG2=2, four L/R pairs with left bin 0 = (1000, 0) each → only the 4th left frame is emitted; bin 0 = 1000000. Right frames emit 0 with out_channel=1.
- Full-scale: every bin (−2^23, −2^23), AVG_LOG2=2 → every output = 2^47, no overflow.
- Backpressure: data_out.ready toggled 1-0-0-1 pseudo-randomly on output frames → data_in.ready mirrors stalls; no bin lost or duplicated; data stable while valid && !ready.
- last asserted at k=9 with N_FFT=16 → frame_err=1 and stays 1. The next frame is treated as the other channel starting at k=0.
- reset_n pulsed low mid-accumulation (f=2) → outputs 0 immediately. After release, the first emitted left frame reflects only post-reset data.
